freq_counter_meas: RTL and testbench
====================================

Name: freq_counter_meas

Overview:
Measures the frequency of an external square wave by counting its rising edges over a fixed gate window of system-clock cycles.
It is the measuring end of the PMOD loopback test: the 6.25 MHz test generator drives the input pin, and this block reports edges per gate.
With the default 1 s gate at 25 MHz, the result is the input frequency in Hz.
Supports single-shot and continuous measurement.

Parameters:
GATE_CYCLES, 25000000, gate window length in i_Clk cycles (>= 2)
COUNT_W, 24, width of the edge counter and result
SYNC_STAGES, 2, flip-flops in the input synchroniser (>= 2)

Ports:
i_Clk  input  1  system clock, 25 MHz
i_Rst_L  input  1  asynchronous active-low reset
i_Freq_In  input  1  asynchronous signal under measurement
i_Start  input  1  single-cycle request to start one measurement
i_Continuous  input  1  1 = back-to-back measurements, no i_Start needed
o_Count  output  COUNT_W  rising edges in the last completed gate (saturated)
o_Valid  output  1  one-cycle pulse: o_Count/o_Overflow just updated
o_Overflow  output  1  last completed gate saturated the counter
o_Busy  output  1  high while a gate window is open

Behaviour:
- Reset (async assert, sync release): state IDLE; synchroniser, edge-detect register, gate counter and edge counter at 0; o_Count=0, o_Valid=0, o_Overflow=0, o_Busy=0.
- Synchroniser and edge-detect register run in every state.
  - edge = sync_out & ~sync_prev.
  - Pin-to-edge latency is SYNC_STAGES+1 cycles.
  - Guaranteed correct when input high and low times are each >= 2 i_Clk periods (i.e. up to 6.25 MHz at 25 MHz).
- States: IDLE, GATE, LATCH.
- IDLE -> GATE when i_Start=1 or i_Continuous=1.
  - On entry: gate counter and edge counter cleared, overflow-pending flag cleared.
- GATE lasts exactly GATE_CYCLES cycles; o_Busy=1 in every GATE cycle.
  - Each cycle with edge=1 increments the edge counter.
  - At all-ones the counter holds and sets overflow-pending.
- On the final GATE cycle, that cycle's edge is included.
  - Registered into o_Count and o_Overflow on the transition to LATCH.
- LATCH: exactly 1 cycle; o_Valid=1, o_Busy=0.
  - If i_Continuous=1 in LATCH -> GATE (counters cleared), else -> IDLE.
  - An edge during LATCH is not counted.
  - Continuous measurement period is GATE_CYCLES+1 cycles.
- o_Count and o_Overflow hold their value until the next LATCH. They are never cleared except by reset.
- i_Start during GATE or LATCH: ignored, not queued.
- i_Start=1 and i_Continuous=1 together in IDLE: single entry into GATE.
- i_Continuous deasserted mid-GATE: current window completes and reports, then IDLE.
- Reset mid-GATE: window discarded, no o_Valid, all outputs return to reset values.
- Gate counter width is ceil(log2(GATE_CYCLES)); it compares against GATE_CYCLES-1 with no wrap-around.

Test Plan:
1. Parameters GATE_CYCLES=100, COUNT_W=24. Input is the 25/4 test generator (period 4 cycles). Single i_Start -> o_Busy high 100 cycles, then o_Valid for 1 cycle with o_Count=25, o_Overflow=0. Repeat at all 4 phase offsets -> 25 each time.
2. Input held 0, then held 1 across a whole gate -> o_Count=0 both times. A 0->1 step inside the gate -> o_Count=1.
3. COUNT_W=4, GATE_CYCLES=100, period-4 input -> o_Count=15, o_Overflow=1. Next gate with static input -> o_Count=0, o_Overflow=0.
4. i_Continuous=1, GATE_CYCLES=100, period-4 input -> o_Valid pulses every 101 cycles, each with o_Count 24 or 25. Deassert i_Continuous mid-window -> exactly one further o_Valid, then IDLE with o_Busy=0.
5. Assert i_Rst_L=0 at gate cycle 50 -> outputs immediately 0, no o_Valid. After release, a fresh i_Start gives a full correct result (25).
6. Pulse i_Start at gate cycles 10 and 99 and in LATCH -> exactly one o_Valid, and the block returns to IDLE.

Source files
------------

// File: rtl/freq_counter_meas.sv
// freq_counter_meas
//   Counts rising edges of an asynchronous square wave over a fixed gate
//   window of GATE_CYCLES system clocks. With a 1 s gate at 25 MHz the
//   result is the input frequency in Hz. It can run single-shot (i_Start)
//   or back-to-back (i_Continuous).
//
// Ports
//   i_Clk        system clock
//   i_Rst_L      asynchronous active-low reset
//   i_Freq_In    asynchronous input under measurement
//   i_Start      one-cycle request for a single measurement (used in IDLE only)
//   i_Continuous back-to-back measurements while high
//   o_Count      rising edges seen in the last completed gate (saturating)
//   o_Valid      one-cycle pulse when o_Count/o_Overflow update
//   o_Overflow   last completed gate saturated the edge counter
//   o_Busy       gate window open
module freq_counter_meas #(
    parameter int GATE_CYCLES = 25000000,
    parameter int COUNT_W     = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Freq_In,
    input  logic               i_Start,
    input  logic               i_Continuous,
    output logic [COUNT_W-1:0] o_Count,
    output logic               o_Valid,
    output logic               o_Overflow,
    output logic               o_Busy
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                 sync_prev;
    logic                 rise;
    logic [GATE_W-1:0]    gate_cnt;
    logic [COUNT_W-1:0]   edge_cnt;
    logic                 ovf_pend;
    logic                 cnt_full;

    // Synchroniser and edge detector run in every state so the first gate
    // cycle already sees a settled sync_prev.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_r    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], i_Freq_In};
            sync_prev <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_r[SYNC_STAGES-1] & ~sync_prev;
    assign cnt_full = &edge_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_pend   <= 1'b0;
            o_Count    <= '0;
            o_Valid    <= 1'b0;
            o_Overflow <= 1'b0;
            o_Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Start || i_Continuous) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_pend <= 1'b0;
                        o_Busy   <= 1'b1;
                    end
                end
                GATE: begin
                    // Saturate: once all-ones, further edges only flag overflow.
                    if (rise) begin
                        if (cnt_full) ovf_pend <= 1'b1;
                        else          edge_cnt <= edge_cnt + COUNT_W'(1);
                    end
                    if (gate_cnt == GATE_LAST) begin
                        // Fold in the final cycle's edge directly since
                        // edge_cnt itself updates on this same clock.
                        state      <= LATCH;
                        o_Busy     <= 1'b0;
                        o_Valid    <= 1'b1;
                        o_Count    <= (rise && !cnt_full) ? edge_cnt + COUNT_W'(1) : edge_cnt;
                        o_Overflow <= ovf_pend | (rise & cnt_full);
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                    end
                end
                LATCH: begin
                    o_Valid <= 1'b0;
                    if (i_Continuous) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_pend <= 1'b0;
                        o_Busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_counter_meas.sv
// Directed bench for freq_counter_meas. Two instances share all inputs:
// dut (COUNT_W=24) and dut4 (COUNT_W=4, used for saturation checks).
module tb_freq_counter_meas;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_Freq_In = 1'b0;
    logic        i_Start = 1'b0;
    logic        i_Continuous = 1'b0;
    logic [23:0] o_Count;
    logic        o_Valid, o_Overflow, o_Busy;
    logic [3:0]  o_Count4;
    logic        o_Valid4, o_Overflow4, o_Busy4;

    int n_cmp = 0;
    int n_bad = 0;

    // Test signal source: period-4 square wave (2 high / 2 low) or a static level.
    logic       sq_en = 1'b0;
    logic       lvl = 1'b0;
    logic [1:0] ph_off = 2'd0;
    logic [1:0] ph = 2'd0;

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) begin
        logic [1:0] t;
        #2;
        ph = ph + 2'd1;
        t = ph + ph_off;
        i_Freq_In = sq_en ? t[1] : lvl;
    end

    freq_counter_meas #(.GATE_CYCLES(100), .COUNT_W(24), .SYNC_STAGES(2)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Freq_In(i_Freq_In),
        .i_Start(i_Start), .i_Continuous(i_Continuous),
        .o_Count(o_Count), .o_Valid(o_Valid), .o_Overflow(o_Overflow), .o_Busy(o_Busy)
    );

    freq_counter_meas #(.GATE_CYCLES(100), .COUNT_W(4), .SYNC_STAGES(2)) dut4 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Freq_In(i_Freq_In),
        .i_Start(i_Start), .i_Continuous(i_Continuous),
        .o_Count(o_Count4), .o_Valid(o_Valid4), .o_Overflow(o_Overflow4), .o_Busy(o_Busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Single-shot gate. step_at >= 0 raises lvl at that gate cycle.
    task automatic measure(input string tag, input int step_at,
                           input logic [31:0] exp_cnt, input logic exp_ovf,
                           input logic [31:0] exp_cnt4, input logic exp_ovf4);
        int busy_n;
        bit got;
        busy_n = 0;
        got = 0;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (o_Valid) begin
                got = 1;
                break;
            end
            if (i == step_at) lvl = 1'b1;
            busy_n += int'(o_Busy);
            tick();
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk({tag, "_valid4"}, 32'(o_Valid4), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd100);
        chk({tag, "_count"}, 32'(o_Count), exp_cnt);
        chk({tag, "_ovf"}, 32'(o_Overflow), 32'(exp_ovf));
        chk({tag, "_count4"}, 32'(o_Count4), exp_cnt4);
        chk({tag, "_ovf4"}, 32'(o_Overflow4), 32'(exp_ovf4));
        tick();
        chk({tag, "_valid_1cyc"}, 32'(o_Valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(o_Busy), 32'd0);
    endtask

    task automatic wait_valid(output int n, output bit got);
        n = 0;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (o_Valid) begin
                got = 1;
                break;
            end
        end
    endtask

    initial begin
        int n;
        bit got;
        int vcnt;

        // Reset state
        #12;
        chk("rst_count", 32'(o_Count), 32'd0);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_ovf", 32'(o_Overflow), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        i_Rst_L = 1'b1;
        tick();

        // Period-4 input at every phase: 25 edges; 4-bit counter saturates at 15
        sq_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ph_off = 2'(k);
            repeat (8) tick();
            measure($sformatf("sq_ph%0d", k), -1, 32'd25, 1'b0, 32'd15, 1'b1);
        end

        // Static levels, then a single 0->1 step inside the gate
        sq_en = 1'b0;
        lvl = 1'b0;
        repeat (6) tick();
        measure("static0", -1, 32'd0, 1'b0, 32'd0, 1'b0);
        lvl = 1'b1;
        repeat (6) tick();
        measure("static1", -1, 32'd0, 1'b0, 32'd0, 1'b0);
        lvl = 1'b0;
        repeat (6) tick();
        measure("step", 50, 32'd1, 1'b0, 32'd1, 1'b0);
        lvl = 1'b0;

        // Continuous: valid every 101 cycles
        sq_en = 1'b1;
        repeat (6) tick();
        i_Continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(n, got);
            chk($sformatf("cont%0d_valid", k), 32'(got), 32'd1);
            if (k > 0) chk($sformatf("cont%0d_period", k), 32'(n), 32'd101);
            chk($sformatf("cont%0d_cnt_ok", k), 32'(o_Count == 24'd24 || o_Count == 24'd25), 32'd1);
        end
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            vcnt += int'(o_Valid);
        end
        chk("cont_mid_novalid", 32'(vcnt), 32'd0);
        i_Continuous = 1'b0;
        wait_valid(n, got);
        chk("cont_last_valid", 32'(got), 32'd1);
        chk("cont_last_delay", 32'(n), 32'd51);
        chk("cont_last_cnt", 32'(o_Count), 32'd25);
        tick();
        chk("cont_end_busy", 32'(o_Busy), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            vcnt += int'(o_Valid) + int'(o_Busy);
        end
        chk("cont_end_idle", 32'(vcnt), 32'd0);

        // Reset in the middle of a gate
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        repeat (50) tick();
        chk("pre_rst_busy", 32'(o_Busy), 32'd1);
        i_Rst_L = 1'b0;
        #1;
        chk("mid_rst_count", 32'(o_Count), 32'd0);
        chk("mid_rst_valid", 32'(o_Valid), 32'd0);
        chk("mid_rst_ovf4", 32'(o_Overflow4), 32'd0);
        chk("mid_rst_busy", 32'(o_Busy), 32'd0);
        tick();
        tick();
        #2;
        i_Rst_L = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            vcnt += int'(o_Valid) + int'(o_Busy);
        end
        chk("post_rst_quiet", 32'(vcnt), 32'd0);
        measure("post_rst", -1, 32'd25, 1'b0, 32'd15, 1'b1);

        // i_Start during GATE and LATCH is ignored
        repeat (4) tick();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 250; i++) begin
            if (i == 10 || i == 99 || i == 100) i_Start = 1'b1;
            else                                i_Start = 1'b0;
            vcnt += int'(o_Valid);
            tick();
        end
        i_Start = 1'b0;
        chk("restart_valids", 32'(vcnt), 32'd1);
        chk("restart_idle_busy", 32'(o_Busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
